// File: rtl/traffic_light_controller.sv
`default_nettype none
// traffic_light_controller: fixed-time round-robin light sequencer for a 4-way intersection.
// Revision 1.0 - initial release
module traffic_light_controller #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk11,
  input  logic       rst11,
  output logic [1:0] out01,
  output logic [1:0] out11,
  output logic [1:0] out21,
  output logic [1:0] out31
);

  localparam int MAX_CYCLES = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [2:0] S_G0 = 3'd0;
  localparam logic [2:0] S_Y0 = 3'd1;
  localparam logic [2:0] S_G1 = 3'd2;
  localparam logic [2:0] S_Y1 = 3'd3;
  localparam logic [2:0] S_G2 = 3'd4;
  localparam logic [2:0] S_Y2 = 3'd5;
  localparam logic [2:0] S_G3 = 3'd6;
  localparam logic [2:0] S_Y3 = 3'd7;

  generate
    if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_params
      $error("traffic_light_controller: GREEN_CYCLES and YELLOW_CYCLES must be >= 1");
    end
  endgenerate

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] count;

  // The phase counter restarts whenever the state changes, so each phase
  // always sees a count starting from zero.
  always_ff @(posedge clk11) begin
    if (rst11) begin
      state <= S_G0;
      count <= '0;
    end else if (next_state != state) begin
      state <= next_state;
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = S_G0;
    case (state)
      S_G0:    next_state = (count == GREEN_LAST)  ? S_Y0 : S_G0;
      S_Y0:    next_state = (count == YELLOW_LAST) ? S_G1 : S_Y0;
      S_G1:    next_state = (count == GREEN_LAST)  ? S_Y1 : S_G1;
      S_Y1:    next_state = (count == YELLOW_LAST) ? S_G2 : S_Y1;
      S_G2:    next_state = (count == GREEN_LAST)  ? S_Y2 : S_G2;
      S_Y2:    next_state = (count == YELLOW_LAST) ? S_G3 : S_Y2;
      S_G3:    next_state = (count == GREEN_LAST)  ? S_Y3 : S_G3;
      S_Y3:    next_state = (count == YELLOW_LAST) ? S_G0 : S_Y3;
      default: next_state = S_G0;
    endcase
  end

  always_comb begin
    out01 = RED;
    out11 = RED;
    out21 = RED;
    out31 = RED;
    case (state)
      S_G0:    out01 = GREEN;
      S_Y0:    out01 = YELLOW;
      S_G1:    out11 = GREEN;
      S_Y1:    out11 = YELLOW;
      S_G2:    out21 = GREEN;
      S_Y2:    out21 = YELLOW;
      S_G3:    out31 = GREEN;
      S_Y3:    out31 = YELLOW;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// tb_traffic_light_controller: directed vector table plus multi-cycle sequences
// for the default, 1/1 and 20/5 parameterisations.
module tb_traffic_light_controller;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam int DG = 8;
  localparam int DY = 3;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [1:0] def_o0, def_o1, def_o2, def_o3;
  logic [1:0] min_o0, min_o1, min_o2, min_o3;
  logic [1:0] big_o0, big_o1, big_o2, big_o3;
  logic [7:0] lights [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_controller #(.GREEN_CYCLES(DG), .YELLOW_CYCLES(DY)) dut_def (
    .clk11(clk), .rst11(rst_v[0]),
    .out01(def_o0), .out11(def_o1), .out21(def_o2), .out31(def_o3)
  );

  traffic_light_controller #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut_min (
    .clk11(clk), .rst11(rst_v[1]),
    .out01(min_o0), .out11(min_o1), .out21(min_o2), .out31(min_o3)
  );

  traffic_light_controller #(.GREEN_CYCLES(20), .YELLOW_CYCLES(5)) dut_big (
    .clk11(clk), .rst11(rst_v[2]),
    .out01(big_o0), .out11(big_o1), .out21(big_o2), .out31(big_o3)
  );

  // Packed as {road0, road1, road2, road3}.
  assign lights[0] = {def_o0, def_o1, def_o2, def_o3};
  assign lights[1] = {min_o0, min_o1, min_o2, min_o3};
  assign lights[2] = {big_o0, big_o1, big_o2, big_o3};

  typedef struct {
    logic       rst;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] mk(input int r, input logic [1:0] c);
    logic [7:0] v;
    v = '0;
    v[(3 - r) * 2 +: 2] = c;
    return v;
  endfunction

  function automatic logic [7:0] exp_at(input int pos, input int g, input int y);
    int p;
    p = pos;
    for (int r = 0; r < 4; r++) begin
      if (p < g) return mk(r, GREEN);
      p = p - g;
      if (p < y) return mk(r, YELLOW);
      p = p - y;
    end
    return 8'hFF;
  endfunction

  function automatic int count_on(input logic [7:0] v);
    int n;
    n = 0;
    for (int r = 0; r < 4; r++) if (v[r * 2 +: 2] != RED) n++;
    return n;
  endfunction

  function automatic logic has_11(input logic [7:0] v);
    for (int r = 0; r < 4; r++) if (v[r * 2 +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic green_to_red(input logic [7:0] prev, input logic [7:0] cur);
    for (int r = 0; r < 4; r++)
      if (prev[r * 2 +: 2] == GREEN && cur[r * 2 +: 2] == RED) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_true(input string name, input logic cond);
    n_checks++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: condition false, expected true (t=%0t)", name, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] exp, input int n);
    vec_t v;
    v.rst = rst;
    v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_rotation(input int idx, input int g, input int y, input string name);
    int period;
    period = 4 * (g + y);
    rst_v[idx] = 1'b1;
    @(posedge clk); #1;
    check({name, "_reset"}, lights[idx], mk(0, GREEN));
    rst_v[idx] = 1'b0;
    for (int k = 1; k <= period + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s_edge%0d", name, k), lights[idx], exp_at(k % period, g, y));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       found;
    logic [7:0] prev;
    logic [7:0] cur;

    // Reset held 3 cycles, then one full rotation and the start of the next.
    add(1'b1, mk(0, GREEN), 3);
    add(1'b0, mk(0, GREEN), DG - 1);
    add(1'b0, mk(0, YELLOW), DY);
    add(1'b0, mk(1, GREEN), DG);
    add(1'b0, mk(1, YELLOW), DY);
    add(1'b0, mk(2, GREEN), DG);
    add(1'b0, mk(2, YELLOW), DY);
    add(1'b0, mk(3, GREEN), DG);
    add(1'b0, mk(3, YELLOW), DY);
    add(1'b0, mk(0, GREEN), DG);
    add(1'b0, mk(0, YELLOW), 1);

    rst_v = 3'b111;
    foreach (vecs[i]) begin
      rst_v[0] = vecs[i].rst;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), lights[0], vecs[i].exp);
    end

    // Reset pulse in the middle of Y2.
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (lights[0] == mk(2, YELLOW)) found = 1'b1;
    end
    check_true("wait_y2", found);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    check("midreset_g0", lights[0], mk(0, GREEN));
    rst_v[0] = 1'b0;
    for (int k = 1; k < DG; k++) begin
      @(posedge clk); #1;
      check($sformatf("midreset_g0_hold%0d", k), lights[0], mk(0, GREEN));
    end
    @(posedge clk); #1;
    check("midreset_y0", lights[0], mk(0, YELLOW));

    // Invariant monitor under random reset pulses.
    prev = lights[0];
    for (int i = 0; i < 1000; i++) begin
      rst_v[0] = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
      cur = lights[0];
      check_true($sformatf("one_active_%0d", i), count_on(cur) == 1 && !has_11(cur));
      if (rst_v[0]) check($sformatf("rand_reset_%0d", i), cur, mk(0, GREEN));
      else check_true($sformatf("no_green_to_red_%0d", i), !green_to_red(prev, cur));
      prev = cur;
    end
    rst_v[0] = 1'b0;

    check_rotation(1, 1, 1, "min");
    check_rotation(2, 20, 5, "big");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
